mem_req_buffer: RTL
===================

MEM_REQ_BUFFER -- requirements
Module: mem_req_buffer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_BITS, 28, request address width (matches MEM_ADDR_BITS).
- TAG_BITS, 5, request/response tag width (matches MEM_TAG_BITS).
- DATA_BITS, 128, write-data beat width (matches MEM_DATA_BITS).
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- DATA_CYCLES, 4, response beats per read; power of two, at least 2.
- MAX_RD, 4, maximum reads in flight; range 1..15.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- in_req_valid / in_req_ready, in / out, 1 / 1, upstream request handshake from the arbiter side.
- in_req_rw, in, 1, 1 = write, 0 = read.
- in_req_addr, in, ADDR_BITS, request address.
- in_req_tag, in, TAG_BITS, request tag.
- in_data_valid / in_data_ready, in / out, 1 / 1, upstream write-data handshake.
- in_data_bits, in, DATA_BITS, write-data beat.
- in_data_mask, in, DATA_BITS/8, write-data byte mask.
- mem_req_valid / mem_req_ready, out / in, 1 / 1, main-memory request handshake.
- mem_req_rw, mem_req_addr, mem_req_tag, out, 1 / ADDR_BITS / TAG_BITS, head-of-queue request fields.
- mem_req_data_valid / mem_req_data_ready, out / in, 1 / 1, main-memory write-data handshake.
- mem_req_data_bits, mem_req_data_mask, out, DATA_BITS / DATA_BITS/8, head-of-queue data beat.
- mem_resp_valid, in, 1, main-memory response beat strobe.
- rd_outstanding, out, 4, reads issued whose final response beat has not yet arrived.
- idle, out, 1, both FIFOs empty and rd_outstanding == 0.
- resp_err, out, 1, sticky flag: a response beat arrived with no read outstanding.

Function
REQ-003 SHALL hold requests {rw, addr, tag} in a DEPTH-entry request FIFO and {bits, mask} in an independent DEPTH-entry data FIFO; each FIFO SHALL preserve order.
REQ-004 SHALL push on in_*_valid && in_*_ready, where in_req_ready = request FIFO not full and in_data_ready = data FIFO not full; a pop in the same cycle SHALL NOT raise ready when the FIFO is full.
REQ-005 SHALL present only registered storage on mem_* outputs (no fall-through): an entry pushed in cycle N is first visible in cycle N+1.
REQ-006 SHALL drive mem_req_data_valid = data FIFO not empty, and pop the data FIFO on mem_req_data_valid && mem_req_data_ready.
REQ-007 SHALL drive mem_req_valid = request FIFO not empty && (head rw == 1 || rd_outstanding < MAX_RD), and pop the request FIFO on mem_req_valid && mem_req_ready.
REQ-008 SHALL keep all mem_req_* fields stable while mem_req_valid is high and mem_req_ready is low; the same rule applies to the data channel.
REQ-009 SHALL keep count unchanged and advance both pointers on a simultaneous push and pop; pointers SHALL wrap modulo DEPTH.
REQ-010 SHALL increment rd_outstanding on each read-request handshake and count mem_resp_valid beats in a modulo-DATA_CYCLES beat counter; when the beat counter wraps, rd_outstanding SHALL decrement.
REQ-011 SHALL leave rd_outstanding unchanged when an increment and a decrement occur in the same cycle.
REQ-012 SHALL ignore mem_resp_valid while rd_outstanding == 0: beat counter unchanged, resp_err set to 1 and held until reset.
REQ-013 SHALL ignore mem_resp_tag (no such port); responses are assumed in issue order and are routed elsewhere.
REQ-014 SHALL compute idle combinationally from the FIFO counts and rd_outstanding.

Reset
REQ-015 SHALL, on reset low (any cycle, including mid-transfer): empty both FIFOs, zero all pointers, counts, the beat counter and rd_outstanding, and clear resp_err; all in-flight entries are discarded.
REQ-016 SHALL, during reset, drive outputs to: mem_req_valid = 0, mem_req_data_valid = 0, in_req_ready = 1, in_data_ready = 1, idle = 1, rd_outstanding = 0, resp_err = 0.

Verification
REQ-017 Push reads with tags 0..3 while mem_req_ready = 0 -> in_req_ready drops after the 4th push; release ready -> tags issue in order 0,1,2,3, one per cycle.
REQ-018 MAX_RD = 2, queue 3 reads with mem_req_ready = 1 -> 2 issue and the 3rd is held with mem_req_valid = 0; 4 response beats -> rd_outstanding 2 -> 1 and the 3rd read issues the next cycle.
REQ-019 Write request with 4 data beats (mask 16'hFFFF), data ready toggling -> beats emerge in order, with bits and mask stable across stalls.
REQ-020 Full FIFO with simultaneous push attempt and pop -> push refused, count becomes 3, in_req_ready = 1 the next cycle.
REQ-021 mem_resp_valid pulse while idle -> resp_err = 1 and held, rd_outstanding stays 0.
REQ-022 Reset asserted mid-burst with 2 reads outstanding and 3 entries queued -> all outputs take the REQ-016 values immediately; after release, idle = 1.

Source files
------------

// File: rtl/mem_req_buffer.sv
// mem_req_buffer
//   Decouples the request arbiter from main memory. Requests {rw, addr, tag}
//   and write-data beats {bits, mask} are queued in two independent in-order
//   FIFOs. All mem_* fields come straight from FIFO storage (no fall-through).
//   Read issue is throttled to MAX_RD reads in flight. Each read retires after
//   DATA_CYCLES response beats.
//
// Ports
//   clk, reset (async, active-low)
//   in_req_*   : upstream request handshake + fields (rw, addr, tag)
//   in_data_*  : upstream write-data handshake + fields (bits, mask)
//   mem_req_*  : head-of-queue request toward memory
//   mem_req_data_* : head-of-queue write-data beat toward memory
//   mem_resp_valid : response beat strobe from memory
//   rd_outstanding : reads issued and not yet fully answered
//   idle       : both FIFOs empty and nothing outstanding
//   resp_err   : sticky, a beat arrived while no read was outstanding
module mem_req_buffer #(
  parameter int ADDR_BITS   = 28,
  parameter int TAG_BITS    = 5,
  parameter int DATA_BITS   = 128,
  parameter int DEPTH       = 4,
  parameter int DATA_CYCLES = 4,
  parameter int MAX_RD      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_req_valid,
  output logic                   in_req_ready,
  input  logic                   in_req_rw,
  input  logic [ADDR_BITS-1:0]   in_req_addr,
  input  logic [TAG_BITS-1:0]    in_req_tag,
  input  logic                   in_data_valid,
  output logic                   in_data_ready,
  input  logic [DATA_BITS-1:0]   in_data_bits,
  input  logic [DATA_BITS/8-1:0] in_data_mask,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  output logic [3:0]             rd_outstanding,
  output logic                   idle,
  output logic                   resp_err
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int BEAT_W    = $clog2(DATA_CYCLES);
  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int REQ_W     = 1 + ADDR_BITS + TAG_BITS;
  localparam int DAT_W     = DATA_BITS + MASK_BITS;

  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ZERO_CNT   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_CNT    = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0]  ONE_PTR    = PTR_W'(1'b1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(DATA_CYCLES - 1);
  localparam logic [BEAT_W-1:0] ONE_BEAT   = BEAT_W'(1'b1);
  localparam logic [3:0]        MAX_RD_CNT = 4'(MAX_RD);

  // Storage (no reset needed: contents are only observed when the count says valid)
  logic [REQ_W-1:0] req_mem_r [DEPTH];
  logic [DAT_W-1:0] dat_mem_r [DEPTH];

  logic [PTR_W-1:0]  req_wr_ptr_r, req_rd_ptr_r, dat_wr_ptr_r, dat_rd_ptr_r;
  logic [CNT_W-1:0]  req_cnt_r, dat_cnt_r;
  logic [BEAT_W-1:0] beat_cnt_r;
  logic [3:0]        rd_out_r;
  logic              resp_err_r;

  logic req_push_s, req_pop_s, dat_push_s, dat_pop_s;
  logic rd_inc_s, rd_dec_s, resp_ok_s, resp_bad_s;
  logic req_empty_s, dat_empty_s;

  // Handshakes, head-of-queue fields and status outputs
  always_comb begin
    req_empty_s        = (req_cnt_r == ZERO_CNT);
    dat_empty_s        = (dat_cnt_r == ZERO_CNT);
    in_req_ready       = (req_cnt_r != FULL_CNT);
    in_data_ready      = (dat_cnt_r != FULL_CNT);
    {mem_req_rw, mem_req_addr, mem_req_tag}  = req_mem_r[req_rd_ptr_r];
    {mem_req_data_bits, mem_req_data_mask}   = dat_mem_r[dat_rd_ptr_r];
    // A write at the head is never blocked by the read limit.
    mem_req_valid      = !req_empty_s && (mem_req_rw || (rd_out_r < MAX_RD_CNT));
    mem_req_data_valid = !dat_empty_s;
    req_push_s         = in_req_valid && in_req_ready;
    req_pop_s          = mem_req_valid && mem_req_ready;
    dat_push_s         = in_data_valid && in_data_ready;
    dat_pop_s          = mem_req_data_valid && mem_req_data_ready;
    rd_inc_s           = req_pop_s && !mem_req_rw;
    resp_ok_s          = mem_resp_valid && (rd_out_r != 4'd0);
    resp_bad_s         = mem_resp_valid && (rd_out_r == 4'd0);
    rd_dec_s           = resp_ok_s && (beat_cnt_r == LAST_BEAT);
    rd_outstanding     = rd_out_r;
    resp_err           = resp_err_r;
    idle               = req_empty_s && dat_empty_s && (rd_out_r == 4'd0);
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (req_push_s) begin
      req_mem_r[req_wr_ptr_r] <= {in_req_rw, in_req_addr, in_req_tag};
    end
    if (dat_push_s) begin
      dat_mem_r[dat_wr_ptr_r] <= {in_data_bits, in_data_mask};
    end
  end

  // Request FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_wr_ptr_r <= {PTR_W{1'b0}};
      req_rd_ptr_r <= {PTR_W{1'b0}};
      req_cnt_r    <= ZERO_CNT;
    end else begin
      if (req_push_s) req_wr_ptr_r <= req_wr_ptr_r + ONE_PTR;
      if (req_pop_s)  req_rd_ptr_r <= req_rd_ptr_r + ONE_PTR;
      case ({req_push_s, req_pop_s})
        2'b10:   req_cnt_r <= req_cnt_r + ONE_CNT;
        2'b01:   req_cnt_r <= req_cnt_r - ONE_CNT;
        default: req_cnt_r <= req_cnt_r;
      endcase
    end
  end

  // Data FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dat_wr_ptr_r <= {PTR_W{1'b0}};
      dat_rd_ptr_r <= {PTR_W{1'b0}};
      dat_cnt_r    <= ZERO_CNT;
    end else begin
      if (dat_push_s) dat_wr_ptr_r <= dat_wr_ptr_r + ONE_PTR;
      if (dat_pop_s)  dat_rd_ptr_r <= dat_rd_ptr_r + ONE_PTR;
      case ({dat_push_s, dat_pop_s})
        2'b10:   dat_cnt_r <= dat_cnt_r + ONE_CNT;
        2'b01:   dat_cnt_r <= dat_cnt_r - ONE_CNT;
        default: dat_cnt_r <= dat_cnt_r;
      endcase
    end
  end

  // Read tracking: beat counter, outstanding reads, sticky stray-beat flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
      rd_out_r   <= 4'd0;
      resp_err_r <= 1'b0;
    end else begin
      // Stray beats (nothing outstanding) leave the beat counter untouched.
      if (resp_ok_s) beat_cnt_r <= beat_cnt_r + ONE_BEAT;
      if (resp_bad_s) resp_err_r <= 1'b1;
      case ({rd_inc_s, rd_dec_s})
        2'b10:   rd_out_r <= rd_out_r + 4'd1;
        2'b01:   rd_out_r <= rd_out_r - 4'd1;
        default: rd_out_r <= rd_out_r;
      endcase
    end
  end

endmodule
